// File: rtl/mem_dumper.sv
// Debug memory dumper: walks a word range of a synchronous-read memory and
// streams each word with its address over a valid/ready port.
module mem_dumper #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    READ   = 3'd2,
    SEND   = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH + 1)'(0);

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   ptr_r, ptr_s;
  logic [ADDR_WIDTH:0]     remaining_r, remaining_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_s;
  logic                    out_valid_s;
  logic [DATA_WIDTH-1:0]   out_data_s;
  logic [ADDR_WIDTH-1:0]   out_addr_s;
  logic                    busy_s;
  logic                    done_s;

  // Next-state and next-output computation for the dump sequencer.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    remaining_s = remaining_r;
    mem_addr_s  = mem_addr;
    out_valid_s = out_valid;
    out_data_s  = out_data;
    out_addr_s  = out_addr;
    done_s      = 1'b0;

    case (state_r)
      IDLE: begin
        // abort in IDLE swallows a simultaneous start
        if (abort) begin
          state_s = IDLE;
        end else if (start) begin
          if (count != CNT_ZERO) begin
            ptr_s       = base_addr;
            remaining_s = count;
            mem_addr_s  = base_addr;
            state_s     = ISSUE;
          end else begin
            state_s = FINISH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = READ;
      end
      READ: begin
        out_data_s  = mem_dout;
        out_addr_s  = ptr_r;
        out_valid_s = 1'b1;
        remaining_s = remaining_r - CNT_ONE;
        state_s     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          if (remaining_r != CNT_ZERO) begin
            ptr_s      = ptr_r + ADDR_ONE;
            mem_addr_s = ptr_r + ADDR_ONE;
            state_s    = ISSUE;
          end else begin
            state_s = FINISH;
          end
        end else begin
          state_s = SEND;
        end
      end
      FINISH: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // abort outranks any handshake or completion in flight
    if (abort && (state_r != IDLE)) begin
      state_s     = IDLE;
      out_valid_s = 1'b0;
      done_s      = 1'b0;
    end else begin
      state_s = state_s;
    end

    busy_s = (state_s != IDLE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      remaining_r <= '0;
      mem_addr    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      remaining_r <= remaining_s;
      mem_addr    <= mem_addr_s;
      out_valid   <= out_valid_s;
      out_data    <= out_data_s;
      out_addr    <= out_addr_s;
      busy        <= busy_s;
      done        <= done_s;
    end
  end

endmodule

// File: tb/tb_mem_dumper.sv
// Randomized self-checking bench for mem_dumper against a queue-based model
// of the words a dump must deliver.
module tb_mem_dumper;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [0:DEPTH-1];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int vld_cnt  = 0;
  int got_a[$];
  int got_d[$];
  int exp_a[$];
  int exp_d[$];

  logic          hold_r = 1'b0;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] hold_addr;

  mem_dumper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory behind the debug port.
  always @(posedge clk) mem_dout <= mem[mem_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: collects accepted words, counts pulses, checks hold stability.
  always @(posedge clk) begin
    if (rstn) begin
      if (out_valid && out_ready && !abort) begin
        got_a.push_back(int'(out_addr));
        got_d.push_back(int'(out_data));
      end
      if (done) done_cnt++;
      if (out_valid) vld_cnt++;
      if (hold_r && out_valid) begin
        check("hold_data", out_data, hold_data);
        check("hold_addr", out_addr, hold_addr);
      end
      hold_r    <= out_valid && !out_ready && !abort;
      hold_data <= out_data;
      hold_addr <= out_addr;
    end else begin
      hold_r <= 1'b0;
    end
  end

  // mode 0: ready always high; 1: random ready; 2: ready low 5 cycles per word
  task automatic do_dump(input int base, input int cnt, input int mode, input bit noise);
    int n;
    int guard;
    int first_v;
    int hold;
    int a0;
    exp_a.delete(); exp_d.delete(); got_a.delete(); got_d.delete();
    for (int i = 0; i < cnt; i++) begin
      exp_a.push_back((base + i) % DEPTH);
      exp_d.push_back(int'(mem[(base + i) % DEPTH]));
    end
    @(negedge clk);
    done_cnt = 0; vld_cnt = 0;
    a0 = int'(mem_addr);
    start = 1'b1; base_addr = AW'(base); count = (AW+1)'(cnt);
    out_ready = (mode == 0);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0; guard = cnt * 40 + 50; first_v = -1; hold = 0;
    while (n < guard) begin
      if (out_valid && first_v < 0) first_v = n;
      if (done) break;
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (out_valid) begin
        out_ready = (hold >= 5);
        hold = out_ready ? 0 : hold + 1;
      end else out_ready = 1'b0;
      start = noise && busy && ($urandom_range(0, 1) == 1);
      base_addr = AW'($urandom);
      count = (AW+1)'($urandom_range(0, 7));
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("done_seen", done, 1);
    if (cnt > 0) check("first_valid_latency", first_v, 2);
    else begin
      check("zero_no_valid", vld_cnt, 0);
      check("zero_no_read", mem_addr, a0);
    end
    if (mode == 0) check("dump_cycles", n, 3 * cnt + 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("done_pulses", done_cnt, 1);
    check("word_count", got_a.size(), cnt);
    for (int i = 0; i < cnt && i < got_a.size(); i++) begin
      check("word_addr", got_a[i], exp_a[i]);
      check("word_data", got_d[i], exp_d[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_addr"}, out_addr, 0);
    check({tag, "_memaddr"}, mem_addr, 0);
  endtask

  initial begin
    int seen;
    int guard;
    logic prev_v;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    base_addr = '0; count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 32'h11);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    do_dump(4, 3, 0, 1'b0);
    do_dump(10, 4, 2, 1'b0);
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    do_dump(1022, 3, 0, 1'b0);
    do_dump(0, 0, 0, 1'b0);
    do_dump(int'($urandom_range(0, DEPTH - 1)), DEPTH, 0, 1'b0);

    // abort during the second SEND of a four-word dump
    @(negedge clk);
    got_a.delete(); got_d.delete();
    start = 1'b1; base_addr = AW'(100); count = (AW+1)'(4); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; seen = 0; guard = 0; prev_v = 1'b0;
    while (seen < 2 && guard < 50) begin
      if (out_valid && !prev_v) seen++;
      prev_v = out_valid;
      if (seen < 2) begin
        @(negedge clk);
        guard++;
      end
    end
    check("abort_reached_send", seen, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_words", got_a.size(), 1);
    done_cnt = 0; vld_cnt = 0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_valid", vld_cnt, 0);
    do_dump(200, 2, 1, 1'b0);

    // abort and start together in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1; base_addr = AW'(5); count = (AW+1)'(3);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
    vld_cnt = 0;
    repeat (8) @(negedge clk);
    check("abort_start_no_valid", vld_cnt, 0);

    // reset in the middle of a dump
    start = 1'b1; base_addr = AW'(300); count = (AW+1)'(6); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rstn = 1'b1;
    done_cnt = 0; vld_cnt = 0;
    repeat (15) @(negedge clk);
    check("midreset_no_done", done_cnt, 0);
    check("midreset_no_valid", vld_cnt, 0);
    check("midreset_idle", busy, 0);

    for (int k = 0; k < 8; k++)
      do_dump(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 2)), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
